// File: rtl/mem_requester_pkg.sv
// mem_requester shared types and constants.
// Widths, FSM encodings and the request payload bundle.
package mem_requester_pkg;

  localparam int LEN_MEM_ADDR = 32;
  localparam int LEN_WORD     = 32;

  localparam logic IO_READ  = 1'b0;
  localparam logic IO_WRITE = 1'b1;

  typedef enum logic [1:0] {
    MREQ_IDLE  = 2'd0,
    MREQ_ORDER = 2'd1,
    MREQ_WAIT  = 2'd2
  } mreq_state_e;

  typedef struct packed {
    logic                    write;
    logic [LEN_MEM_ADDR-1:0] addr;
    logic [LEN_WORD-1:0]     wdata;
  } mreq_t;

  localparam mreq_t MREQ_NONE = '{
    write: IO_READ,
    addr:  '0,
    wdata: '0
  };

endpackage

// File: rtl/mem_req_slot.sv
// One-entry holding register for the pending request.
// Push wins over pop so a drain and refill can share a cycle.
module mem_req_slot
  import mem_requester_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  push_i,
  input  logic  pop_i,
  input  mreq_t data_i,
  output logic  full_o,
  output mreq_t data_o
);

  logic  full_q, full_d;
  mreq_t data_q, data_d;

  // next occupancy and payload
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (push_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  // slot registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      full_q <= 1'b0;
      data_q <= MREQ_NONE;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/mem_requester.sv
// Memory port initiator: one access in flight plus one pending.
// Optional watchdog enabled by defining MEM_REQ_TIMEOUT_EN.
module mem_requester
  import mem_requester_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [LEN_MEM_ADDR-1:0] req_addr,
  input  logic [LEN_WORD-1:0]     req_wdata,
  output logic                    resp_valid,
  output logic                    resp_write,
  output logic [LEN_WORD-1:0]     resp_rdata,
  output logic                    busy,
  output logic                    order,
  output logic                    io,
  output logic [LEN_MEM_ADDR-1:0] address,
  output logic [LEN_WORD-1:0]     i_data,
  input  logic                    accepted,
  input  logic                    accessed,
  input  logic [LEN_WORD-1:0]     o_data,
  output logic                    timeout_err
);

  mreq_state_e         state_q, state_d;
  mreq_t               act_q, act_d;
  mreq_t               req_in, slot_data;
  logic                slot_full, slot_push, slot_pop;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_write_q, resp_write_d;
  logic [LEN_WORD-1:0] resp_rdata_q, resp_rdata_d;
  logic                xfer, done, tmo_hit, finish;

  assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = !slot_full;
  assign xfer = req_valid & req_ready;
  assign done = accessed &
                ((state_q == MREQ_WAIT) |
                 ((state_q == MREQ_ORDER) & accepted));
  assign finish = done | tmo_hit;

  mem_req_slot u_slot (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (slot_push),
    .pop_i  (slot_pop),
    .data_i (req_in),
    .full_o (slot_full),
    .data_o (slot_data)
  );

  // next state, active request and response
  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    resp_valid_d = 1'b0;
    resp_write_d = resp_write_q;
    resp_rdata_d = resp_rdata_q;
    slot_push    = 1'b0;
    slot_pop     = 1'b0;
    unique case (state_q)
      MREQ_IDLE: begin
        if (xfer) begin
          act_d   = req_in;
          state_d = MREQ_ORDER;
        end
      end
      MREQ_ORDER: begin
        if (accepted && !accessed) state_d = MREQ_WAIT;
      end
      MREQ_WAIT: ;
      default: state_d = MREQ_IDLE;
    endcase
    if (state_q != MREQ_IDLE) begin
      if (finish) begin
        resp_valid_d = 1'b1;
        resp_write_d = act_q.write;
        if (!done) resp_rdata_d = '0;
        else if (act_q.write == IO_READ) resp_rdata_d = o_data;
        if (slot_full) begin
          act_d     = slot_data;
          slot_pop  = 1'b1;
          slot_push = xfer;
          state_d   = MREQ_ORDER;
        end else if (xfer) begin
          act_d   = req_in;
          state_d = MREQ_ORDER;
        end else begin
          state_d = MREQ_IDLE;
        end
      end else begin
        slot_push = xfer;
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= MREQ_IDLE;
      act_q        <= MREQ_NONE;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_err_q;

  assign tmo_hit = (state_q != MREQ_IDLE) &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // cycles spent in the current busy state
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_q == MREQ_IDLE || state_d != state_q || finish)
      cnt_d = '0;
  end

  // watchdog counter and sticky error
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_q | tmo_hit;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign order      = (state_q == MREQ_ORDER);
  assign io         = act_q.write;
  assign address    = act_q.addr;
  assign i_data     = act_q.wdata;
  assign busy       = (state_q != MREQ_IDLE) | slot_full;
  assign resp_valid = resp_valid_q;
  assign resp_write = resp_write_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: memory model plus response scoreboard.
// Build with MEM_REQ_TIMEOUT_EN to run the watchdog scenario.
module tb_mem_requester;
  import mem_requester_pkg::*;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    req_valid, req_ready, req_write;
  logic [LEN_MEM_ADDR-1:0] req_addr;
  logic [LEN_WORD-1:0]     req_wdata;
  logic                    resp_valid, resp_write;
  logic [LEN_WORD-1:0]     resp_rdata;
  logic                    busy, order, io;
  logic [LEN_MEM_ADDR-1:0] address;
  logic [LEN_WORD-1:0]     i_data;
  logic                    accepted, accessed;
  logic [LEN_WORD-1:0]     o_data;
  logic                    timeout_err;

  always #5 clk = ~clk;

  mem_requester #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .busy(busy),
    .order(order), .io(io), .address(address),
    .i_data(i_data), .accepted(accepted),
    .accessed(accessed), .o_data(o_data),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic                w;
    logic [LEN_WORD-1:0] d;
  } exp_t;

  exp_t                sb[$];
  logic [LEN_WORD-1:0] exp_rd;
  int                  n_cmp = 0;
  int                  n_bad = 0;

  // memory model controls
  logic                mem_manual = 1'b1;
  int                  acc_dly = 0;
  int                  access_dly = 0;
  logic                man_acc = 1'b0, man_accd = 1'b0;
  logic [LEN_WORD-1:0] man_od = '0;
  logic                m_acc = 1'b0, m_accd = 1'b0;
  logic [LEN_WORD-1:0] m_od = '0;
  int                  m_ph = 0, m_cnt = 0, stab_viol = 0;
  logic [LEN_MEM_ADDR-1:0] m_addr;
  logic                m_io;
  logic [LEN_WORD-1:0] m_wd;

  assign accepted = mem_manual ? man_acc : m_acc;
  assign accessed = mem_manual ? man_accd : m_accd;
  assign o_data   = mem_manual ? man_od : m_od;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], 16'h5A00} ^ 32'h0F0F_1234;
  endfunction

  // memory responder: accept acc_dly cycles after order, then
  // finish access_dly cycles after acceptance
  always @(posedge clk) begin
    #1;
    m_acc  = 1'b0;
    m_accd = 1'b0;
    if (mem_manual) begin
      m_ph = 0;
    end else begin
      if (m_ph == 1 && (address !== m_addr || io !== m_io ||
                        i_data !== m_wd))
        stab_viol++;
      if (m_ph == 0 && order === 1'b1) begin
        m_ph = 1; m_cnt = 0;
        m_addr = address; m_io = io; m_wd = i_data;
      end
      if (m_ph == 1) begin
        if (m_cnt >= acc_dly) begin
          m_acc = 1'b1;
          if (access_dly == 0) begin
            m_accd = 1'b1; m_od = mem_data(m_addr); m_ph = 0;
          end else begin
            m_ph = 2; m_cnt = 0;
          end
        end else m_cnt++;
      end else if (m_ph == 2) begin
        m_cnt++;
        if (m_cnt >= access_dly) begin
          m_accd = 1'b1; m_od = mem_data(m_addr); m_ph = 0;
        end
      end
    end
  end

  task automatic push_exp(input logic w, input logic [31:0] a);
    if (!w) exp_rd = mem_data(a);
    sb.push_back('{w: w, d: exp_rd});
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({order, io, address, i_data, resp_valid, resp_write,
         resp_rdata, busy, timeout_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got order=%b io=%b addr=%h busy=%b rv=%b rd=%h te=%b want all 0",
               order, io, address, busy, resp_valid, resp_rdata, timeout_err);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    exp_rd = '0;
  endtask

  task automatic run_single(input string nm, input logic w,
                            input logic [31:0] a,
                            input logic [31:0] wd);
    int oh = 0, nr = 0, rc = -1, sv0;
    exp_t e;
    sv0 = stab_viol;
    mem_manual = 1'b0; acc_dly = 2; access_dly = 3;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s_ready: got %b want 1", nm, req_ready);
    end
    push_exp(w, a);
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if ({order, io, address, i_data} !== {1'b1, w, a, wd}) begin
          n_bad++;
          $display("FAIL %s_issue: got order=%b io=%b addr=%h data=%h want 1 %b %h %h",
                   nm, order, io, address, i_data, w, a, wd);
        end
      end
      if (order === 1'b1) oh++;
      if (resp_valid === 1'b1) begin
        nr++; rc = c;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL %s_extra_resp: got resp want none", nm);
        end else begin
          e = sb.pop_front();
          if (resp_write !== e.w || resp_rdata !== e.d) begin
            n_bad++;
            $display("FAIL %s_resp: got w=%b d=%h want w=%b d=%h",
                     nm, resp_write, resp_rdata, e.w, e.d);
          end
        end
      end
    end
    n_cmp++;
    if (oh != 3) begin
      n_bad++; $display("FAIL %s_order_len: got %0d want 3", nm, oh);
    end
    n_cmp++;
    if (nr != 1 || rc != 6) begin
      n_bad++;
      $display("FAIL %s_resp_count: got %0d at c%0d want 1 at c6", nm, nr, rc);
    end
    n_cmp++;
    if (stab_viol != sv0) begin
      n_bad++; $display("FAIL %s_stable: got %0d changes want 0", nm, stab_viol - sv0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL %s_idle: got busy=%b want 0", nm, busy);
    end
  endtask

  task automatic test_single_load();
    run_single("load", 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_single_store();
    run_single("store", 1'b1, 32'h20, 32'h12345678);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ad[3] = '{32'h100, 32'h104, 32'h108};
    logic        wr[3] = '{1'b0, 1'b1, 1'b0};
    int k = 0, nr = 0, rdy_lo = 0, hi = 0, fh = -1, lh = -1;
    exp_t e;
    mem_manual = 1'b0; acc_dly = 1; access_dly = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      req_valid = (k < 3);
      if (k < 3) begin
        req_write = wr[k]; req_addr = ad[k]; req_wdata = 32'hCAFE0000 + k;
      end
      @(negedge clk);
      if (req_valid && req_ready) begin
        push_exp(wr[k], ad[k]); k++;
      end else if (req_valid) rdy_lo++;
      if (order === 1'b1) begin
        hi++; lh = c; if (fh < 0) fh = c;
      end
      if (resp_valid === 1'b1) begin
        nr++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL b2b_extra_resp: got resp want none");
        end else begin
          e = sb.pop_front();
          if (resp_write !== e.w || resp_rdata !== e.d) begin
            n_bad++;
            $display("FAIL b2b_resp%0d: got w=%b d=%h want w=%b d=%h",
                     nr, resp_write, resp_rdata, e.w, e.d);
          end
        end
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (rdy_lo == 0) begin
      n_bad++; $display("FAIL b2b_ready_drop: got 0 stalled cycles want >0");
    end
    n_cmp++;
    if (nr != 3 || k != 3) begin
      n_bad++; $display("FAIL b2b_count: got %0d resp %0d req want 3 3", nr, k);
    end
    n_cmp++;
    if (hi != 6 || lh - fh + 1 != hi) begin
      n_bad++;
      $display("FAIL b2b_order_gap: got %0d high over %0d cycles want 6 contiguous",
               hi, lh - fh + 1);
    end
  endtask

  task automatic test_early_accessed();
    exp_t e;
    mem_manual = 1'b1; man_acc = 1'b0; man_accd = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h30;
    @(negedge clk);
    push_exp(1'b0, 32'h30);
    @(posedge clk); #1;
    req_valid = 1'b0; man_accd = 1'b1; man_od = 32'hBAD0BAD0;
    @(negedge clk);
    @(posedge clk); #1;
    man_accd = 1'b0; man_acc = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (order !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL early_ignored: got order=%b rv=%b want 1 0", order, resp_valid);
    end
    @(posedge clk); #1;
    man_acc = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (order !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL early_wait: got order=%b busy=%b want 0 1", order, busy);
    end
    @(posedge clk); #1;
    man_accd = 1'b1; man_od = mem_data(32'h30);
    @(posedge clk); #1;
    man_accd = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b1 || sb.size() == 0) begin
      n_bad++; $display("FAIL early_resp: got rv=%b want 1", resp_valid);
    end else begin
      e = sb.pop_front();
      if (resp_write !== e.w || resp_rdata !== e.d) begin
        n_bad++;
        $display("FAIL early_data: got w=%b d=%h want w=%b d=%h",
                 resp_write, resp_rdata, e.w, e.d);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nr = 0;
    mem_manual = 1'b0; acc_dly = 0; access_dly = 5;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
    @(negedge clk);
    push_exp(1'b0, 32'h40);
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    mem_manual = 1'b1; man_acc = 1'b0; man_accd = 1'b0;
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({order, io, address, i_data, resp_valid, resp_write,
         resp_rdata, busy, timeout_err} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got order=%b addr=%h busy=%b rv=%b rd=%h want all 0",
               order, address, busy, resp_valid, resp_rdata);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) nr++;
    end
    n_cmp++;
    if (nr != 0) begin
      n_bad++; $display("FAIL midreset_noresp: got %0d want 0", nr);
    end
    sb.delete();
    exp_rd = '0;
    run_single("after_reset", 1'b0, 32'h44, 32'h0);
  endtask

`ifdef MEM_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int te_c = -1, rc = -1, nr = 0;
    exp_t e;
    mem_manual = 1'b1; man_acc = 1'b0; man_accd = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50;
    @(negedge clk);
    exp_rd = '0;
    sb.push_back('{w: 1'b0, d: 32'h0});
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (timeout_err === 1'b1 && te_c < 0) te_c = c;
      if (resp_valid === 1'b1) begin
        nr++; rc = c;
        n_cmp++;
        e = sb.pop_front();
        if (resp_write !== e.w || resp_rdata !== e.d) begin
          n_bad++;
          $display("FAIL tmo_resp: got w=%b d=%h want w=%b d=%h",
                   resp_write, resp_rdata, e.w, e.d);
        end
      end
    end
    n_cmp++;
    if (te_c != 8 || rc != 8 || nr != 1) begin
      n_bad++;
      $display("FAIL tmo_timing: got err@%0d resp@%0d n=%0d want 8 8 1",
               te_c, rc, nr);
    end
    n_cmp++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_sticky: got err=%b busy=%b want 1 0", timeout_err, busy);
    end
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++; $display("FAIL tmo_clear: got %b want 0", timeout_err);
    end
  endtask
`else
  task automatic test_no_timeout();
    int oh = 0, nr = 0, te = 0;
    mem_manual = 1'b1; man_acc = 1'b0; man_accd = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (order === 1'b1) oh++;
      if (resp_valid === 1'b1) nr++;
      if (timeout_err !== 1'b0) te++;
    end
    n_cmp++;
    if (oh != 40 || nr != 0 || te != 0) begin
      n_bad++;
      $display("FAIL no_tmo: got order=%0d resp=%0d err=%0d want 40 0 0",
               oh, nr, te);
    end
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    exp_rd = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_load();
    test_single_store();
    test_back_to_back();
    test_early_accessed();
    test_reset_mid();
`ifdef MEM_REQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL sb_drained: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
